phase1_wr_sched: RTL and testbench
==================================

Name: phase1_wr_sched

Overview:
- Sequences the phase-1 write passes of one merge tree (trees 4 and 12) onto the AXI write master.
- Ping-pongs the output between two adjacent DDR channel buffers: pass 0 goes to channel C_CHANNEL_OFFSET+1, pass 1 to C_CHANNEL_OFFSET, and so on alternately.
- Gates each pass on merge-tree data readiness, issues one write command per pass and waits for write completion.
- Signals phase-1 completion after the configured number of passes. Sits between the kernel control FSM, the merge tree and the AXI write master.

Parameters:
C_M_AXI_ADDR_WIDTH, 64, AXI byte-address width
C_XFER_SIZE_WIDTH, 64, byte-count width per pass
C_CHANNEL_OFFSET, 0, index of the even channel of the ping-pong pair
C_CH_SIZE_LOG2, 30, log2 of the per-channel byte span (1 GiB)
C_PASS_W, 8, pass-counter width

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
i_phase_1_start  in  1  one-cycle pulse; latches config and starts the phase
i_ptr_ch_0  in  C_M_AXI_ADDR_WIDTH  base address of channel 0
i_num_pass  in  C_PASS_W  number of passes in this phase
i_xfer_size  in  C_XFER_SIZE_WIDTH  bytes written per pass
i_src_ready  in  1  merge tree has output ready for the next pass (level)
i_wr_done  in  1  one-cycle pulse; write master finished the current pass
o_wr_start  out  1  one-cycle pulse; command to the write master
o_wr_addr  out  C_M_AXI_ADDR_WIDTH  start address of the current pass
o_wr_size  out  C_XFER_SIZE_WIDTH  byte count of the current pass
o_pass_idx  out  C_PASS_W  index of the current pass
o_busy  out  1  high from the cycle after an accepted start until done
o_phase_1_done  out  1  one-cycle completion pulse

Behaviour:
- Clock aclk. Reset areset is synchronous and active-high. All outputs are registered.
- Reset values: every output is 0; FSM is in IDLE; all internal counters are 0.
- Reset mid-operation: return to IDLE next cycle. Any outstanding write is abandoned; no done pulse is generated.
- Address generation:
  - ptr0 = i_ptr_ch_0 + (C_CHANNEL_OFFSET << C_CH_SIZE_LOG2)
  - ptr1 = ptr0 + (1 << C_CH_SIZE_LOG2)
  - Sums wrap modulo 2^C_M_AXI_ADDR_WIDTH.
  - Both pointers are computed and registered at start.
- Pass addressing: even pass_idx -> ptr1; odd pass_idx -> ptr0.
- FSM states: IDLE, WAIT_SRC, ISSUE, WAIT_DONE, DONE.
- IDLE:
  - On i_phase_1_start, latch i_num_pass, i_xfer_size and the pointers; clear pass_idx.
  - If i_num_pass==0 or i_xfer_size==0, go to DONE. Otherwise go to WAIT_SRC.
- WAIT_SRC: when i_src_ready is sampled high at cycle t, go to ISSUE.
- ISSUE (cycle t+1):
  - o_wr_start=1 for exactly one cycle.
  - o_wr_addr and o_wr_size are valid in the same cycle and held stable until the next ISSUE.
  - Next state is WAIT_DONE.
- WAIT_DONE: on i_wr_done at cycle d, increment pass_idx.
  - If the incremented value equals num_pass, go to DONE at d+1.
  - Otherwise go to WAIT_SRC at d+1.
- DONE: o_phase_1_done=1 for one cycle, o_busy=0, then IDLE.
- o_busy: 1 in WAIT_SRC, ISSUE and WAIT_DONE.
- Ignored events:
  - i_phase_1_start outside IDLE.
  - i_wr_done outside WAIT_DONE, including the ISSUE cycle.
  - i_src_ready outside WAIT_SRC.
- i_wr_done and i_src_ready high together in WAIT_DONE: done is processed; readiness is re-sampled in WAIT_SRC.
- Minimum per-pass cycle: WAIT_SRC 1, ISSUE 1, WAIT_DONE ≥1.
- pass_idx width: C_PASS_W; num_pass up to 2^C_PASS_W-1. The counter never wraps.

Decomposition:
- Shared package (wr_sched_pkg):
  - FSM state enum wr_sched_state_t.
  - Helper function for channel base computation (offset << size_log2).
- One natural sub-module: phase1_ch_ptr_gen, the registered ptr0/ptr1 calculator. Reusable by the phase-2 scheduler.

Test Plan:
- Normal run, i_ptr_ch_0=0x0, OFFSET=0, num_pass=3, size=0x1000, src_ready held high -> three o_wr_start pulses:
  - addresses 0x4000_0000, 0x0, 0x4000_0000, all size 0x1000;
  - o_phase_1_done one cycle after the 3rd i_wr_done.
- Latency: src_ready rises at cycle 10 -> o_wr_start at cycle 11. i_wr_done at cycle 20 with num_pass=1 -> o_phase_1_done at 21; o_busy low at 21.
- Degenerate configs: num_pass=0 -> o_phase_1_done one cycle after start and no o_wr_start. Same response for size=0.
- Spurious inputs: i_wr_done during ISSUE or WAIT_SRC, and a second i_phase_1_start while busy -> no state, pass_idx or address change.
- Reset at pass 1 in WAIT_DONE -> next cycle all outputs 0 and IDLE. A new start then begins at pass 0 with address ptr1.
- Wrap: i_ptr_ch_0=0xFFFF_FFFF_C000_0000, OFFSET=0 -> pass 0 address 0x0, pass 1 address 0xFFFF_FFFF_C000_0000.

Source files
------------

// File: rtl/wr_sched_pkg.sv
// Shared types and helpers for the merge-tree write schedulers.
package wr_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SRC,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_DONE
  } wr_sched_state_t;

  localparam int unsigned CH_BASE_W = 128;

  // Byte offset of channel 'idx' when each channel spans 2**size_log2 bytes.
  function automatic logic [CH_BASE_W-1:0] ch_base(input int unsigned idx,
                                                   input int unsigned size_log2);
    return CH_BASE_W'(idx) << size_log2;
  endfunction

endpackage

// File: rtl/phase1_ch_ptr_gen.sv
// Registered ping-pong channel pointer pair: ptr0 = even channel, ptr1 = the next one up.
module phase1_ch_ptr_gen
  import wr_sched_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_CHANNEL_OFFSET   = 0,
  parameter int unsigned C_CH_SIZE_LOG2     = 30
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          load_i,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ptr_ch_0_i,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] ptr0_o,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] ptr1_o
);

  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BASE =
    C_M_AXI_ADDR_WIDTH'(ch_base(C_CHANNEL_OFFSET, C_CH_SIZE_LOG2));
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] SPAN =
    C_M_AXI_ADDR_WIDTH'(ch_base(1, C_CH_SIZE_LOG2));

  logic [C_M_AXI_ADDR_WIDTH-1:0] ptr0_d, ptr1_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] ptr0_q, ptr1_q;

  always_comb begin
    ptr0_d = ptr_ch_0_i + BASE;
    ptr1_d = ptr0_d + SPAN;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr0_q <= '0;
      ptr1_q <= '0;
    end else if (load_i) begin
      ptr0_q <= ptr0_d;
      ptr1_q <= ptr1_d;
    end
  end

  assign ptr0_o = ptr0_q;
  assign ptr1_o = ptr1_q;

endmodule

// File: rtl/phase1_wr_sched.sv
// Phase-1 write-pass sequencer: one write command per pass, ping-ponging between two channels.
module phase1_wr_sched
  import wr_sched_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_XFER_SIZE_WIDTH  = 64,
  parameter int unsigned C_CHANNEL_OFFSET   = 0,
  parameter int unsigned C_CH_SIZE_LOG2     = 30,
  parameter int unsigned C_PASS_W           = 8
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          i_phase_1_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_ptr_ch_0,
  input  logic [C_PASS_W-1:0]           i_num_pass,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  i_xfer_size,
  input  logic                          i_src_ready,
  input  logic                          i_wr_done,
  output logic                          o_wr_start,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] o_wr_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]  o_wr_size,
  output logic [C_PASS_W-1:0]           o_pass_idx,
  output logic                          o_busy,
  output logic                          o_phase_1_done
);

  wr_sched_state_t state_q, state_d;

  logic [C_PASS_W-1:0]           pass_q, pass_d;
  logic [C_PASS_W-1:0]           num_q, num_d;
  logic [C_XFER_SIZE_WIDTH-1:0]  xfer_q, xfer_d;
  logic                          load_ptr;
  logic [C_M_AXI_ADDR_WIDTH-1:0] ptr0, ptr1;

  logic                          wr_start_q, wr_start_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [C_XFER_SIZE_WIDTH-1:0]  wr_size_q, wr_size_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  phase1_ch_ptr_gen #(
    .C_M_AXI_ADDR_WIDTH(C_M_AXI_ADDR_WIDTH),
    .C_CHANNEL_OFFSET  (C_CHANNEL_OFFSET),
    .C_CH_SIZE_LOG2    (C_CH_SIZE_LOG2)
  ) u_ptr_gen (
    .clk_i     (aclk),
    .rst_i     (areset),
    .load_i    (load_ptr),
    .ptr_ch_0_i(i_ptr_ch_0),
    .ptr0_o    (ptr0),
    .ptr1_o    (ptr1)
  );

  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    num_d    = num_q;
    xfer_d   = xfer_q;
    load_ptr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_phase_1_start) begin
          load_ptr = 1'b1;
          num_d    = i_num_pass;
          xfer_d   = i_xfer_size;
          pass_d   = '0;
          if (i_num_pass == '0 || i_xfer_size == '0) state_d = ST_DONE;
          else                                       state_d = ST_WAIT_SRC;
        end
      end
      ST_WAIT_SRC: if (i_src_ready) state_d = ST_ISSUE;
      ST_ISSUE:    state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (i_wr_done) begin
          pass_d  = pass_q + 1'b1;
          state_d = (pass_d == num_q) ? ST_DONE : ST_WAIT_SRC;
        end
      end
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they register in step with the FSM.
  always_comb begin
    wr_start_d = (state_d == ST_ISSUE);
    busy_d     = (state_d == ST_WAIT_SRC) || (state_d == ST_ISSUE) ||
                 (state_d == ST_WAIT_DONE);
    done_d     = (state_d == ST_DONE);
    wr_addr_d  = wr_addr_q;
    wr_size_d  = wr_size_q;
    if (state_d == ST_ISSUE) begin
      wr_addr_d = pass_q[0] ? ptr0 : ptr1;
      wr_size_d = xfer_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      pass_q     <= '0;
      num_q      <= '0;
      xfer_q     <= '0;
      wr_start_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_size_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass_d;
      num_q      <= num_d;
      xfer_q     <= xfer_d;
      wr_start_q <= wr_start_d;
      wr_addr_q  <= wr_addr_d;
      wr_size_q  <= wr_size_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_wr_start     = wr_start_q;
  assign o_wr_addr      = wr_addr_q;
  assign o_wr_size      = wr_size_q;
  assign o_pass_idx     = pass_q;
  assign o_busy         = busy_q;
  assign o_phase_1_done = done_q;

endmodule

// File: tb/tb_phase1_wr_sched.sv
// Directed and randomized checks of phase1_wr_sched against a pass-level reference model.
module tb_phase1_wr_sched;

  localparam int unsigned AW = 64;
  localparam int unsigned SW = 64;
  localparam int unsigned PW = 8;
  localparam logic [63:0] CH_SPAN = 64'h4000_0000;

  logic          aclk = 1'b0;
  logic          areset;
  logic          i_phase_1_start;
  logic [AW-1:0] i_ptr_ch_0;
  logic [PW-1:0] i_num_pass;
  logic [SW-1:0] i_xfer_size;
  logic          i_src_ready;
  logic          i_wr_done;
  logic          o_wr_start;
  logic [AW-1:0] o_wr_addr;
  logic [SW-1:0] o_wr_size;
  logic [PW-1:0] o_pass_idx;
  logic          o_busy;
  logic          o_phase_1_done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  phase1_wr_sched #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_XFER_SIZE_WIDTH (SW),
    .C_CHANNEL_OFFSET  (0),
    .C_CH_SIZE_LOG2    (30),
    .C_PASS_W          (PW)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .i_phase_1_start(i_phase_1_start),
    .i_ptr_ch_0     (i_ptr_ch_0),
    .i_num_pass     (i_num_pass),
    .i_xfer_size    (i_xfer_size),
    .i_src_ready    (i_src_ready),
    .i_wr_done      (i_wr_done),
    .o_wr_start     (o_wr_start),
    .o_wr_addr      (o_wr_addr),
    .o_wr_size      (o_wr_size),
    .o_pass_idx     (o_pass_idx),
    .o_busy         (o_busy),
    .o_phase_1_done (o_phase_1_done)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Reference: even passes go to the odd channel (base + one span), odd passes to the base.
  function automatic logic [63:0] exp_addr(input logic [63:0] ptr, input int unsigned k);
    return (k % 2 == 0) ? ptr + CH_SPAN : ptr;
  endfunction

  function automatic logic rbit(input bit en);
    return en && ($urandom_range(0, 1) == 1);
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_start"}, 64'(o_wr_start), 64'd0);
    chk({tag, "_busy"},  64'(o_busy), 64'd0);
    chk({tag, "_done"},  64'(o_phase_1_done), 64'd0);
  endtask

  // Runs a whole phase; when stop_at_pass1 is set, resets the DUT during pass 1 WAIT_DONE.
  task automatic run_phase(input logic [63:0] ptr, input int unsigned n,
                           input logic [63:0] size, input bit noisy, input bit stop_at_pass1);
    logic [63:0] last_addr;
    i_ptr_ch_0 = ptr; i_num_pass = PW'(n); i_xfer_size = size; i_phase_1_start = 1'b1;
    step();
    i_phase_1_start = 1'b0;
    i_ptr_ch_0 = {$urandom, $urandom}; i_num_pass = PW'($urandom); i_xfer_size = {$urandom, $urandom};
    if (n == 0 || size == 0) begin
      chk("degen_done", 64'(o_phase_1_done), 64'd1);
      chk("degen_busy", 64'(o_busy), 64'd0);
      chk("degen_start", 64'(o_wr_start), 64'd0);
      step();
      chk_idle_outputs("degen_after");
      return;
    end
    chk("start_busy", 64'(o_busy), 64'd1);
    chk("start_done", 64'(o_phase_1_done), 64'd0);
    for (int unsigned k = 0; k < n; k++) begin
      int unsigned w;
      w = noisy ? $urandom_range(0, 4) : 0;
      for (int unsigned j = 0; j < w; j++) begin
        i_src_ready = 1'b0; i_wr_done = rbit(noisy); i_phase_1_start = rbit(noisy);
        step();
        chk("wsrc_start", 64'(o_wr_start), 64'd0);
        chk("wsrc_pass", 64'(o_pass_idx), 64'(k));
        chk("wsrc_busy", 64'(o_busy), 64'd1);
      end
      i_src_ready = 1'b1; i_wr_done = rbit(noisy); i_phase_1_start = rbit(noisy);
      step();
      last_addr = exp_addr(ptr, k);
      chk("issue_start", 64'(o_wr_start), 64'd1);
      chk("issue_addr", o_wr_addr, last_addr);
      chk("issue_size", o_wr_size, size);
      chk("issue_pass", 64'(o_pass_idx), 64'(k));
      chk("issue_busy", 64'(o_busy), 64'd1);
      i_src_ready = rbit(noisy); i_wr_done = rbit(noisy); i_phase_1_start = rbit(noisy);
      step();
      chk("wdone_start", 64'(o_wr_start), 64'd0);
      chk("wdone_addr", o_wr_addr, last_addr);
      chk("wdone_pass", 64'(o_pass_idx), 64'(k));
      if (stop_at_pass1 && k == 1) begin
        areset = 1'b1; i_wr_done = 1'b1; i_src_ready = 1'b1;
        step();
        areset = 1'b0; i_wr_done = 1'b0; i_src_ready = 1'b0;
        chk_idle_outputs("rst");
        chk("rst_addr", o_wr_addr, 64'd0);
        chk("rst_size", o_wr_size, 64'd0);
        chk("rst_pass", 64'(o_pass_idx), 64'd0);
        step();
        chk_idle_outputs("rst_after");
        return;
      end
      w = $urandom_range(0, 3);
      for (int unsigned j = 0; j < w; j++) begin
        i_wr_done = 1'b0; i_src_ready = rbit(noisy); i_phase_1_start = rbit(noisy);
        step();
        chk("wdone_hold_start", 64'(o_wr_start), 64'd0);
        chk("wdone_hold_addr", o_wr_addr, last_addr);
        chk("wdone_hold_busy", 64'(o_busy), 64'd1);
        chk("wdone_hold_done", 64'(o_phase_1_done), 64'd0);
      end
      i_wr_done = 1'b1; i_src_ready = rbit(noisy); i_phase_1_start = rbit(noisy);
      step();
      i_wr_done = 1'b0; i_src_ready = 1'b0; i_phase_1_start = 1'b0;
      chk("post_done_start", 64'(o_wr_start), 64'd0);
      chk("post_done_pass", 64'(o_pass_idx), 64'(k + 1));
      if (k == n - 1) begin
        chk("phase_done", 64'(o_phase_1_done), 64'd1);
        chk("phase_done_busy", 64'(o_busy), 64'd0);
      end else begin
        chk("next_pass_done", 64'(o_phase_1_done), 64'd0);
        chk("next_pass_busy", 64'(o_busy), 64'd1);
      end
    end
    step();
    chk_idle_outputs("end");
    chk("end_addr_held", o_wr_addr, last_addr);
  endtask

  initial begin
    areset = 1'b1; i_phase_1_start = 1'b0; i_ptr_ch_0 = '0; i_num_pass = '0;
    i_xfer_size = '0; i_src_ready = 1'b0; i_wr_done = 1'b0;
    step(); step();
    chk_idle_outputs("reset");
    chk("reset_addr", o_wr_addr, 64'd0);
    chk("reset_size", o_wr_size, 64'd0);
    chk("reset_pass", 64'(o_pass_idx), 64'd0);
    areset = 1'b0;
    step();
    chk_idle_outputs("idle");

    // Ignored inputs while idle.
    i_src_ready = 1'b1; i_wr_done = 1'b1;
    step();
    i_src_ready = 1'b0; i_wr_done = 1'b0;
    chk_idle_outputs("idle_spurious");

    run_phase(64'h0, 3, 64'h1000, 1'b0, 1'b0);
    run_phase(64'h0, 1, 64'h80, 1'b0, 1'b0);
    run_phase(64'h0, 0, 64'h1000, 1'b0, 1'b0);
    run_phase(64'h1234_0000, 4, 64'h0, 1'b0, 1'b0);
    run_phase(64'hFFFF_FFFF_C000_0000, 2, 64'h200, 1'b1, 1'b0);
    run_phase(64'h10_0000_0000, 4, 64'h40, 1'b1, 1'b1);
    run_phase(64'h20_0000_0000, 2, 64'h40, 1'b1, 1'b0);
    for (int unsigned r = 0; r < 20; r++) begin
      run_phase({$urandom, $urandom}, $urandom_range(0, 6),
                ($urandom_range(0, 7) == 0) ? 64'h0 : 64'($urandom_range(1, 65535)),
                1'b1, 1'b0);
    end
    run_phase(64'h8000_0000, 255, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
